// File: rtl/wb_daq_regs_pkg.sv
// Shared register map, register-select encoding and byte-lane merge helper
// for the DAQ Wishbone register block and its per-channel slices.
package wb_daq_regs_pkg;

    localparam logic [31:0] CONTROL_OFFSET    = 32'h00;
    localparam logic [31:0] INT_STATUS_OFFSET = 32'h04;
    localparam logic [31:0] INT_ENABLE_OFFSET = 32'h08;
    localparam logic [31:0] ID_OFFSET         = 32'h0C;
    localparam logic [31:0] CH_BASE           = 32'h10;
    localparam logic [31:0] CH_STRIDE         = 32'h10;
    localparam logic [31:0] CH_ADDRESS_OFFSET = 32'h0;
    localparam logic [31:0] CH_CONTROL_OFFSET = 32'h4;
    localparam logic [31:0] CH_STATUS_OFFSET  = 32'h8;

    localparam logic [7:0]  ID_MAGIC          = 8'hDA;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_CONTROL,
        REG_INT_STATUS,
        REG_INT_ENABLE,
        REG_ID,
        REG_CH_ADDRESS,
        REG_CH_CONTROL,
        REG_CH_STATUS
    } reg_sel_e;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] wr_val,
                                               input logic [3:0]  lanes);
        logic [31:0] res;
        for (int k = 0; k < 4; k++) begin
            res[8*k +: 8] = lanes[k] ? wr_val[8*k +: 8] : old_val[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_daq_ch_regs.sv
// One DAQ channel: ADDRESS/CONTROL with byte-lane writes, done-edge detector, pending bit.
// Latency: writes land on the clock edge of the strobe; pending sets one edge after done rises. No backpressure.
module wb_daq_ch_regs
    import wb_daq_regs_pkg::*;
(
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic        addr_we,
    input  logic        ctrl_we,
    input  logic [3:0]  wr_sel,
    input  logic [31:0] wr_dat,
    input  logic        done,
    input  logic        pend_clr,
    output logic [31:0] address,
    output logic [31:0] control,
    output logic        pend
);

    logic done_q;
    logic rise;

    assign rise = done & ~done_q;

    // A new rising edge wins over a simultaneous write-1-to-clear.
    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            done_q  <= 1'b0;
            address <= '0;
            control <= '0;
            pend    <= 1'b0;
        end else begin
            done_q <= done;
            if (addr_we) address <= byte_merge(address, wr_dat, wr_sel);
            if (ctrl_we) control <= byte_merge(control, wr_dat, wr_sel);
            pend <= rise | (pend & ~pend_clr);
        end
    end

endmodule

// File: rtl/wb_daq_regs_multi.sv
// Parametrised Wishbone B3 DAQ register slave with interrupt pending/enable and error on unmapped access.
// Latency: ack/err one cycle after request, held one cycle; next request accepted the cycle after; no wait states.
module wb_daq_regs_multi
    import wb_daq_regs_pkg::*;
#(
    parameter int         NUM_CH  = 4,
    parameter int         AW      = 8,
    parameter logic [7:0] VERSION = 8'h02
) (
    input  logic                   wb_clk,
    input  logic                   wb_rst,
    input  logic [AW-1:0]          wb_adr_i,
    input  logic [31:0]            wb_dat_i,
    input  logic [3:0]             wb_sel_i,
    input  logic                   wb_we_i,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    input  logic [2:0]             wb_cti_i,
    input  logic [1:0]             wb_bte_i,
    output logic [31:0]            wb_dat_o,
    output logic                   wb_ack_o,
    output logic                   wb_err_o,
    output logic                   wb_rty_o,
    output logic [31:0]            daq_control_o,
    output logic [32*NUM_CH-1:0]   ch_address_o,
    output logic [32*NUM_CH-1:0]   ch_control_o,
    input  logic [32*NUM_CH-1:0]   ch_status_i,
    output logic                   interrupt
);

    localparam int         CHW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [7:0] NUM_CH_B = 8'(NUM_CH);

    logic              req;
    logic              wr_en;
    logic              mapped;
    reg_sel_e          reg_sel;
    logic [CHW-1:0]    ch_idx;
    logic [31:0]       adr_word;
    logic [31:0]       ch_rel;
    logic [31:0]       ch_num;
    logic [31:0]       ch_sub;
    logic [31:0]       rdata;
    logic [31:0]       control_q;
    logic [NUM_CH-1:0] int_status;
    logic [NUM_CH-1:0] int_enable;
    logic [31:0]       ch_addr [NUM_CH];
    logic [31:0]       ch_ctrl [NUM_CH];
    logic              unused_bus;

    // cti/bte carry no meaning here: every beat is a classic single access.
    assign unused_bus = ^{wb_cti_i, wb_bte_i};

    assign req    = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
    assign mapped = (reg_sel != REG_NONE);
    assign wr_en  = req & wb_we_i & mapped;

    assign wb_rty_o      = 1'b0;
    assign daq_control_o = control_q;

    always_comb begin
        reg_sel  = REG_NONE;
        ch_idx   = '0;
        adr_word = 32'(wb_adr_i) & ~32'h3;
        ch_rel   = adr_word - CH_BASE;
        ch_num   = ch_rel / CH_STRIDE;
        ch_sub   = ch_rel % CH_STRIDE;
        if (adr_word == CONTROL_OFFSET) begin
            reg_sel = REG_CONTROL;
        end else if (adr_word == INT_STATUS_OFFSET) begin
            reg_sel = REG_INT_STATUS;
        end else if (adr_word == INT_ENABLE_OFFSET) begin
            reg_sel = REG_INT_ENABLE;
        end else if (adr_word == ID_OFFSET) begin
            reg_sel = REG_ID;
        end else if (adr_word >= CH_BASE && ch_num < 32'(NUM_CH)) begin
            ch_idx = ch_num[CHW-1:0];
            case (ch_sub)
                CH_ADDRESS_OFFSET: reg_sel = REG_CH_ADDRESS;
                CH_CONTROL_OFFSET: reg_sel = REG_CH_CONTROL;
                CH_STATUS_OFFSET:  reg_sel = REG_CH_STATUS;
                default:           reg_sel = REG_NONE;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_CONTROL:    rdata = control_q;
            REG_INT_STATUS: rdata = 32'(int_status);
            REG_INT_ENABLE: rdata = 32'(int_enable);
            REG_ID:         rdata = {8'h00, NUM_CH_B, ID_MAGIC, VERSION};
            REG_CH_ADDRESS: rdata = ch_addr[ch_idx];
            REG_CH_CONTROL: rdata = ch_ctrl[ch_idx];
            REG_CH_STATUS:  rdata = ch_status_i[32*ch_idx +: 32];
            default:        rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            wb_ack_o   <= 1'b0;
            wb_err_o   <= 1'b0;
            wb_dat_o   <= '0;
            control_q  <= '0;
            int_enable <= '0;
            interrupt  <= 1'b0;
        end else begin
            wb_ack_o <= req & mapped;
            wb_err_o <= req & ~mapped;
            if (req & ~wb_we_i) wb_dat_o <= rdata;
            if (wr_en && reg_sel == REG_CONTROL) begin
                control_q <= byte_merge(control_q, wb_dat_i, wb_sel_i);
            end
            if (wr_en && reg_sel == REG_INT_ENABLE && wb_sel_i[0]) begin
                int_enable <= wb_dat_i[NUM_CH-1:0];
            end
            interrupt <= control_q[0] & |(int_status & int_enable);
        end
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        wb_daq_ch_regs u_ch (
            .wb_clk   (wb_clk),
            .wb_rst   (wb_rst),
            .addr_we  (wr_en && reg_sel == REG_CH_ADDRESS && ch_idx == CHW'(n)),
            .ctrl_we  (wr_en && reg_sel == REG_CH_CONTROL && ch_idx == CHW'(n)),
            .wr_sel   (wb_sel_i),
            .wr_dat   (wb_dat_i),
            .done     (ch_status_i[32*n]),
            .pend_clr (wr_en && reg_sel == REG_INT_STATUS && wb_sel_i[0] && wb_dat_i[n]),
            .address  (ch_addr[n]),
            .control  (ch_ctrl[n]),
            .pend     (int_status[n])
        );
        assign ch_address_o[32*n +: 32] = ch_addr[n];
        assign ch_control_o[32*n +: 32] = ch_ctrl[n];
    end

endmodule

// File: tb/tb_wb_daq_regs_multi.sv
// Randomised and directed bench for wb_daq_regs_multi against a register-level reference model.
module tb_wb_daq_regs_multi;

    localparam int NUM_CH = 4;
    localparam int AW     = 8;

    logic                 wb_clk = 1'b0;
    logic                 wb_rst = 1'b0;
    logic [AW-1:0]        wb_adr_i = '0;
    logic [31:0]          wb_dat_i = '0;
    logic [3:0]           wb_sel_i = '0;
    logic                 wb_we_i = 1'b0;
    logic                 wb_cyc_i = 1'b0;
    logic                 wb_stb_i = 1'b0;
    logic [2:0]           wb_cti_i = '0;
    logic [1:0]           wb_bte_i = '0;
    logic [31:0]          wb_dat_o;
    logic                 wb_ack_o;
    logic                 wb_err_o;
    logic                 wb_rty_o;
    logic [31:0]          daq_control_o;
    logic [32*NUM_CH-1:0] ch_address_o;
    logic [32*NUM_CH-1:0] ch_control_o;
    logic [32*NUM_CH-1:0] ch_status_i;
    logic                 interrupt;

    always #5 wb_clk = ~wb_clk;

    wb_daq_regs_multi #(.NUM_CH(NUM_CH), .AW(AW), .VERSION(8'h02)) dut (
        .wb_clk        (wb_clk),
        .wb_rst        (wb_rst),
        .wb_adr_i      (wb_adr_i),
        .wb_dat_i      (wb_dat_i),
        .wb_sel_i      (wb_sel_i),
        .wb_we_i       (wb_we_i),
        .wb_cyc_i      (wb_cyc_i),
        .wb_stb_i      (wb_stb_i),
        .wb_cti_i      (wb_cti_i),
        .wb_bte_i      (wb_bte_i),
        .wb_dat_o      (wb_dat_o),
        .wb_ack_o      (wb_ack_o),
        .wb_err_o      (wb_err_o),
        .wb_rty_o      (wb_rty_o),
        .daq_control_o (daq_control_o),
        .ch_address_o  (ch_address_o),
        .ch_control_o  (ch_control_o),
        .ch_status_i   (ch_status_i),
        .interrupt     (interrupt)
    );

    // Reference model state
    logic [31:0]       m_control;
    logic [NUM_CH-1:0] m_pend;
    logic [NUM_CH-1:0] m_en;
    logic [31:0]       m_addr [NUM_CH];
    logic [31:0]       m_ctrl [NUM_CH];
    logic [31:0]       st     [NUM_CH];

    int n_checks = 0;
    int n_errors = 0;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) ch_status_i[32*i +: 32] = st[i];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_control = '0;
        m_pend    = '0;
        m_en      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_addr[i] = '0;
            m_ctrl[i] = '0;
        end
    endtask

    // -1 unmapped, 0..3 global registers, 4/5/6 channel ADDRESS/CONTROL/STATUS
    function automatic int classify(input int a, output int ch);
        int w;
        w  = a & ~3;
        ch = 0;
        if (w < 16) return w / 4;
        ch = (w - 16) / 16;
        if (ch >= NUM_CH) return -1;
        case ((w - 16) % 16)
            0:       return 4;
            4:       return 5;
            8:       return 6;
            default: return -1;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input int kind, input int ch);
        case (kind)
            0:       return m_control;
            1:       return 32'(m_pend);
            2:       return 32'(m_en);
            3:       return {8'h00, 8'(NUM_CH), 8'hDA, 8'h02};
            4:       return m_addr[ch];
            5:       return m_ctrl[ch];
            6:       return st[ch];
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_write(input int kind, input int ch, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] mask;
        mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
        case (kind)
            0: m_control = (m_control & ~mask) | (d & mask);
            1: if (sel[0]) m_pend = m_pend & ~d[NUM_CH-1:0];
            2: if (sel[0]) m_en = d[NUM_CH-1:0];
            4: m_addr[ch] = (m_addr[ch] & ~mask) | (d & mask);
            5: m_ctrl[ch] = (m_ctrl[ch] & ~mask) | (d & mask);
            default: ;
        endcase
    endtask

    function automatic logic model_irq();
        return m_control[0] & (|(m_pend & m_en));
    endfunction

    task automatic check_outputs();
        check_val("daq_control", daq_control_o, m_control);
        for (int n = 0; n < NUM_CH; n++) begin
            check_val("ch_address", ch_address_o[32*n +: 32], m_addr[n]);
            check_val("ch_control", ch_control_o[32*n +: 32], m_ctrl[n]);
        end
        check_val("interrupt", 32'(interrupt), 32'(model_irq()));
        check_val("rty", 32'(wb_rty_o), 32'h0);
    endtask

    // Drive one access, wait for ack/err with a cycle budget, then idle one cycle.
    task automatic bus(input logic [7:0] adr, input logic [31:0] d, input logic [3:0] sel,
                       input logic we, output logic [31:0] rd, output logic ack,
                       output logic err, output int lat);
        wb_adr_i = adr; wb_dat_i = d; wb_sel_i = sel; wb_we_i = we;
        wb_cti_i = 3'($urandom_range(0, 1) ? 3'b010 : 3'b000);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        ack = 1'b0; err = 1'b0; rd = '0; lat = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge wb_clk); #1;
            if (wb_ack_o || wb_err_o) begin
                ack = wb_ack_o; err = wb_err_o; rd = wb_dat_o; lat = c;
                break;
            end
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(posedge wb_clk); #1;
    endtask

    task automatic do_access(input logic [7:0] adr, input logic [31:0] d, input logic [3:0] sel,
                             input logic we, output logic [31:0] rd);
        int kind, ch, lat;
        logic ack, err, map;
        logic [31:0] exp_rd;
        kind   = classify(int'(adr), ch);
        map    = (kind >= 0);
        exp_rd = map ? model_read(kind, ch) : 32'h0;
        bus(adr, d, sel, we, rd, ack, err, lat);
        check_val("latency", 32'(lat), 32'd1);
        check_val("ack", 32'(ack), 32'(map));
        check_val("err", 32'(err), 32'(!map));
        if (!we) check_val("rdata", rd, exp_rd);
        if (we && map) model_write(kind, ch, d, sel);
        check_val("resp_one_cycle", 32'({wb_ack_o, wb_err_o}), 32'h0);
        check_outputs();
    endtask

    // Change one channel's status; rising done edge marks it pending. Waits until interrupt has settled.
    task automatic set_status(input int ch, input logic [31:0] v);
        if (v[0] && !st[ch][0]) m_pend[ch] = 1'b1;
        st[ch] = v;
        repeat (2) @(posedge wb_clk);
        #1;
    endtask

    initial begin
        logic [31:0] rd;
        int lat;
        logic ack, err;
        for (int i = 0; i < NUM_CH; i++) st[i] = '0;
        model_reset();
        repeat (3) @(posedge wb_clk);
        #1;
        check_val("reset_ack", 32'({wb_ack_o, wb_err_o}), 32'h0);
        check_val("reset_dat", wb_dat_o, 32'h0);
        check_outputs();
        wb_rst = 1'b1;
        @(posedge wb_clk); #1;

        // ID register and its read-only behaviour
        do_access(8'h0C, 32'h0, 4'hF, 1'b0, rd);
        check_val("id_value", rd, 32'h0004DA02);
        do_access(8'h0C, 32'h0000FFFF, 4'hF, 1'b1, rd);
        do_access(8'h0C, 32'h0, 4'hF, 1'b0, rd);
        check_val("id_after_write", rd, 32'h0004DA02);

        // Byte-lane write into ch0 ADDRESS
        do_access(8'h10, 32'h12345678, 4'hF, 1'b1, rd);
        do_access(8'h10, 32'hAABBCCDD, 4'b0010, 1'b1, rd);
        do_access(8'h10, 32'h0, 4'hF, 1'b0, rd);
        check_val("lane_write", rd, 32'h1234CC78);
        check_val("ch0_address_pin", ch_address_o[31:0], 32'h1234CC78);

        do_access(8'h34, 32'hCAFEF00D, 4'hF, 1'b1, rd);
        check_val("ch2_control_pin", ch_control_o[95:64], 32'hCAFEF00D);

        // Unmapped, reserved and out-of-range channel
        do_access(8'h50, 32'hFFFFFFFF, 4'hF, 1'b1, rd);
        do_access(8'h50, 32'h0, 4'hF, 1'b0, rd);
        do_access(8'h1C, 32'hFFFFFFFF, 4'hF, 1'b1, rd);
        do_access(8'h1C, 32'h0, 4'hF, 1'b0, rd);
        check_val("err_read_zero", rd, 32'h0);

        // Interrupt sequence
        do_access(8'h00, 32'h1, 4'hF, 1'b1, rd);
        do_access(8'h08, 32'h2, 4'hF, 1'b1, rd);
        set_status(1, 32'h1);
        check_val("irq_ch1", 32'(interrupt), 32'h1);
        do_access(8'h04, 32'h0, 4'hF, 1'b0, rd);
        check_val("int_status_ch1", rd, 32'h2);
        set_status(1, 32'h0);
        do_access(8'h04, 32'h2, 4'h1, 1'b1, rd);
        check_val("irq_cleared", 32'(interrupt), 32'h0);
        set_status(0, 32'h1);
        do_access(8'h04, 32'h0, 4'hF, 1'b0, rd);
        check_val("int_status_ch0_masked", rd, 32'h1);
        check_val("irq_masked", 32'(interrupt), 32'h0);
        set_status(0, 32'h0);

        // Same-cycle W1C and new rising edge on ch1: set wins
        set_status(1, 32'h1);
        set_status(1, 32'h0);
        st[1] = 32'h1;
        bus(8'h04, 32'h2, 4'h1, 1'b1, rd, ack, err, lat);
        check_val("w1c_race_ack", 32'(ack), 32'h1);
        check_outputs();
        do_access(8'h04, 32'h0, 4'hF, 1'b0, rd);
        check_val("w1c_race_pend", rd[1] ? 32'h1 : 32'h0, 32'h1);
        check_val("w1c_race_irq", 32'(interrupt), 32'h1);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            logic [7:0]  a;
            logic [31:0] d;
            logic [3:0]  s;
            if ($urandom_range(0, 5) == 0) begin
                int c;
                c = $urandom_range(0, NUM_CH - 1);
                set_status(c, {$urandom(), 1'b0} | 32'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 3) == 0) a = 8'($urandom_range(0, 255));
            else a = 8'($urandom_range(0, 4 + 4 * NUM_CH) * 4);
            d = $urandom();
            s = 4'($urandom_range(0, 15));
            do_access(a, d, s, 1'($urandom_range(0, 1)), rd);
        end

        // Reset in the middle of a write
        for (int i = 0; i < NUM_CH; i++) set_status(i, 32'h0);
        wb_adr_i = 8'h00; wb_dat_i = 32'hFFFFFFFF; wb_sel_i = 4'hF; wb_we_i = 1'b1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        @(posedge wb_clk); #1;
        wb_rst = 1'b0;
        #1;
        model_reset();
        check_val("rst_ack_drop", 32'({wb_ack_o, wb_err_o}), 32'h0);
        check_val("rst_dat", wb_dat_o, 32'h0);
        check_outputs();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(posedge wb_clk); #1;
        wb_rst = 1'b1;
        @(posedge wb_clk); #1;
        do_access(8'h00, 32'h0, 4'hF, 1'b0, rd);
        check_val("post_rst_control", rd, 32'h0);
        do_access(8'h04, 32'h0, 4'hF, 1'b0, rd);
        do_access(8'h08, 32'h0, 4'hF, 1'b0, rd);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
